// File: rtl/divider_pkg.sv
// divider_pkg: shared width, FSM encoding and two's-complement helpers for the
// multiplier/divider datapath.
package divider_pkg;
  localparam int WIDTH = 6;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;
  function automatic logic [2*WIDTH-1:0] cond_neg(input logic [2*WIDTH-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction
  function automatic logic [2*WIDTH-1:0] abs_val(input logic [2*WIDTH-1:0] x);
    return cond_neg(x, x[2*WIDTH-1]);
  endfunction
endpackage

// File: rtl/signed_divider.sv
// signed_divider: restoring 2W/W signed divider, truncating quotient, remainder
// signed like the dividend, start/busy/done handshake.
module signed_divider
  import divider_pkg::*;
(
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 div_by_zero,
  output logic                 overflow
);
  localparam int W2 = 2 * WIDTH;
  state_t            state_q, state_d;
  logic [W2-1:0]     dvd_q, dvd_d;
  logic [WIDTH-1:0]  dvs_q, dvs_d;
  logic [WIDTH:0]    rem_q, rem_d, shifted;
  logic [3:0]        cnt_q, cnt_d;
  logic              qneg_q, qneg_d, rneg_q, rneg_d;
  logic [WIDTH-1:0]  quotient_q, quotient_d, remainder_q, remainder_d;
  logic              dbz_q, dbz_d, ovf_q, ovf_d;
  logic              ge, q_ovf;
  always_comb begin
    shifted     = (rem_q << 1) | (WIDTH+1)'(dvd_q[W2-1]);
    ge          = shifted >= {1'b0, dvs_q};
    // a negative quotient may reach one step further than a positive one
    q_ovf       = dvd_q > (qneg_q ? W2'(2**(WIDTH-1)) : W2'(2**(WIDTH-1) - 1));
    state_d     = state_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;
    case (state_q)
      IDLE: if (start) begin
        dvd_d   = dividend;
        dvs_d   = divisor;
        state_d = LOAD;
      end
      LOAD: if (dvs_q == '0) begin
        quotient_d  = '0;
        remainder_d = '0;
        dbz_d       = 1'b1;
        ovf_d       = 1'b0;
        state_d     = DONE;
      end else begin
        dvd_d   = abs_val(dvd_q);
        dvs_d   = dvs_q[WIDTH-1] ? -dvs_q : dvs_q;
        qneg_d  = dvd_q[W2-1] ^ dvs_q[WIDTH-1];
        rneg_d  = dvd_q[W2-1];
        rem_d   = '0;
        cnt_d   = 4'(W2);
        state_d = ITER;
      end
      ITER: begin
        rem_d   = ge ? shifted - {1'b0, dvs_q} : shifted;
        dvd_d   = {dvd_q[W2-2:0], ge};
        cnt_d   = cnt_q - 4'd1;
        state_d = (cnt_q == 4'd1) ? FIX : ITER;
      end
      FIX: begin
        quotient_d  = q_ovf ? '0 : (qneg_q ? -dvd_q[WIDTH-1:0] : dvd_q[WIDTH-1:0]);
        remainder_d = q_ovf ? '0 : (rneg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0]);
        ovf_d       = q_ovf;
        dbz_d       = 1'b0;
        state_d     = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
    end
  end
  assign busy        = state_q != IDLE;
  assign done        = state_q == DONE;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;
endmodule

// File: tb/tb_signed_divider.sv
// tb_signed_divider: directed and random operations; expected results from plain
// integer division are queued at issue and checked by a monitor on each done.
module tb_signed_divider;
  logic        clk = 0, n_rst = 0, start = 0;
  logic [11:0] dividend = 0;
  logic [5:0]  divisor = 0;
  logic        busy, done, div_by_zero, overflow;
  logic [5:0]  quotient, remainder;
  typedef struct {
    logic [5:0] q;
    logic [5:0] r;
    logic       dz;
    logic       ov;
  } exp_t;
  exp_t sb[$];
  int checks = 0, fails = 0, done_cnt = 0;
  signed_divider dut (
    .clk(clk), .n_rst(n_rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic exp_t model(input int a, input int b);
    exp_t e;
    int q, r;
    e = '{q: 6'd0, r: 6'd0, dz: 1'b0, ov: 1'b0};
    if (b == 0) e.dz = 1'b1;
    else begin
      q = a / b;
      r = a % b;
      if (q > 31 || q < -32) e.ov = 1'b1;
      else begin
        e.q = q[5:0];
        e.r = r[5:0];
      end
    end
    return e;
  endfunction
  always @(negedge clk) if (n_rst && done) begin
    exp_t e;
    done_cnt++;
    if (sb.size() == 0) check("unexpected_done", 1, 0);
    else begin
      e = sb.pop_front();
      check("quotient", int'(quotient), int'(e.q));
      check("remainder", int'(remainder), int'(e.r));
      check("div_by_zero", int'(div_by_zero), int'(e.dz));
      check("overflow", int'(overflow), int'(e.ov));
    end
  end
  task automatic do_op(input int a, input int b, input bit hold = 0, input bit pulse = 0);
    exp_t e;
    int n, base;
    e = model(a, b);
    @(negedge clk);
    dividend = a[11:0];
    divisor  = b[5:0];
    start    = 1;
    sb.push_back(e);
    base = done_cnt;
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (!hold) start = 0;
      if (pulse && n == 6) begin
        start = 1;
        dividend = 12'($urandom);
        divisor  = 6'($urandom_range(1, 63));
      end else if (pulse && n == 7) start = 0;
    end
    check("latency", n, (b == 0) ? 2 : 15);
    start = 0;
    repeat (3) @(negedge clk);
    check("busy_after", int'(busy), 0);
    check("one_done", done_cnt - base, 1);
    check("hold_quotient", int'(quotient), int'(e.q));
    check("hold_flags", int'({div_by_zero, overflow}), int'({e.dz, e.ov}));
  endtask
  initial begin
    logic signed [11:0] a12;
    logic signed [5:0]  b6;
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_outs", int'({done, quotient, remainder, div_by_zero, overflow}), 0);
    repeat (2) @(negedge clk);
    n_rst = 1;
    do_op(100, 7);
    do_op(-100, 7);
    do_op(100, -7);
    do_op(-100, -7);
    do_op(1024, -32);
    do_op(-1024, -32);
    do_op(-2048, 1);
    do_op(31, 1);
    do_op(55, 0);
    do_op(9, 3);
    do_op(-2048, -32, 1'b1);
    do_op(-77, 5, 1'b0, 1'b1);
    @(negedge clk);
    dividend = 12'd100;
    divisor  = 6'd7;
    start    = 1;
    @(negedge clk);
    start = 0;
    repeat (5) @(negedge clk);
    check("busy_mid", int'(busy), 1);
    n_rst = 0;
    #1;
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_outs", int'({done, quotient, remainder, div_by_zero, overflow}), 0);
    repeat (3) @(negedge clk);
    check("rst_no_done", int'(done), 0);
    n_rst = 1;
    do_op(100, 7);
    for (int i = 0; i < 40; i++) begin
      a12 = 12'($urandom);
      b6  = (i % 8 == 0) ? 6'sd0 : 6'($urandom);
      do_op(int'(a12), int'(b6));
    end
    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
